// File: rtl/pwd_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwd_signal_ctrl
// Description : Registered password-difference classifier driving the RGB LED,
//               with consecutive-failure counting and timed blinking lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module pwd_signal_ctrl #(
    parameter int WIDTH       = 5,
    parameter int NEAR_THR    = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 500000000,
    parameter int BLINK_HALF  = 12500000,
    parameter int FAIL_W      = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In_valid,
    input  logic [WIDTH-1:0]  In,
    output logic [2:0]        LED,
    output logic [FAIL_W-1:0] fail_count,
    output logic              locked,
    output logic              busy
);

    localparam int c_TMR_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_BLK_W   = $clog2(BLINK_HALF + 1);

    localparam logic [c_TMR_W-1:0] c_HOLD_LD = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LOCK_LD = c_TMR_W'(LOCK_CYCLES - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LD  = c_BLK_W'(BLINK_HALF - 1);
    localparam logic [WIDTH:0]     c_NEAR    = (WIDTH + 1)'(NEAR_THR);
    localparam logic [FAIL_W-1:0]  c_MAX     = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0]  c_LAST    = FAIL_W'(MAX_FAIL - 1);

    localparam logic [2:0] c_LED_OFF   = 3'b000;
    localparam logic [2:0] c_LED_GREEN = 3'b001;
    localparam logic [2:0] c_LED_BLUE  = 3'b010;
    localparam logic [2:0] c_LED_RED   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_BLK_W-1:0] r_blk;

    logic [WIDTH:0]     w_in_ext;
    logic [WIDTH:0]     w_mag;
    logic               w_exact;
    logic               w_near;
    logic               w_lock_hit;
    logic [FAIL_W-1:0]  w_fail_inc;

    // One extra bit keeps |most-negative| representable, so it lands in FAR.
    assign w_in_ext   = {In[WIDTH-1], In};
    assign w_mag      = In[WIDTH-1] ? -w_in_ext : w_in_ext;
    assign w_exact    = (In == '0);
    assign w_near     = !w_exact && (w_mag <= c_NEAR);
    assign w_fail_inc = fail_count + FAIL_W'(1);
    assign w_lock_hit = (fail_count >= c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_blk      <= '0;
            LED        <= c_LED_OFF;
            fail_count <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (In_valid) begin
                        busy <= 1'b1;
                        if (w_exact) begin
                            LED        <= c_LED_GREEN;
                            fail_count <= '0;
                            r_tmr      <= c_HOLD_LD;
                            r_state    <= S_SHOW;
                        end else if (w_lock_hit) begin
                            // Lockout shows only red, starting in its on phase.
                            LED        <= c_LED_RED;
                            fail_count <= c_MAX;
                            locked     <= 1'b1;
                            r_tmr      <= c_LOCK_LD;
                            r_blk      <= c_BLK_LD;
                            r_state    <= S_LOCK;
                        end else begin
                            LED        <= w_near ? c_LED_BLUE : c_LED_RED;
                            fail_count <= w_fail_inc;
                            r_tmr      <= c_HOLD_LD;
                            r_state    <= S_SHOW;
                        end
                    end
                end
                S_SHOW: begin
                    if (r_tmr == '0) begin
                        LED     <= c_LED_OFF;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                S_LOCK: begin
                    if (r_tmr == '0) begin
                        LED        <= c_LED_OFF;
                        fail_count <= '0;
                        locked     <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                        if (r_blk == '0) begin
                            LED   <= {~LED[2], 2'b00};
                            r_blk <= c_BLK_LD;
                        end else begin
                            r_blk <= r_blk - c_BLK_W'(1);
                        end
                    end
                end
                default: begin
                    LED     <= c_LED_OFF;
                    locked  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pwd_signal_ctrl.md
Name: pwd_signal_ctrl

Overview:
- Registered, parametrised successor of the combinational password-difference LED classifier.
- Takes a signed difference (attempt minus stored password) with a valid strobe and classifies it as EXACT (0), NEAR (|diff| <= NEAR_THR, nonzero) or FAR.
- Shows the result on the RGB LED for a fixed hold time and counts consecutive failures.
- After MAX_FAIL failures, enters a timed lockout with a blinking red LED.
- Sits between the subtractor and the board RGB LED pins.

Parameters:
- WIDTH, 5: width of the two's-complement difference input.
- NEAR_THR, 3: largest nonzero |diff| classified NEAR. Legal range 0..2^(WIDTH-1)-1; 0 disables NEAR.
- HOLD_CYCLES, 50000000: number of cycles a result stays displayed (>= 1).
- MAX_FAIL, 3: consecutive failures that trigger lockout (>= 1).
- LOCK_CYCLES, 500000000: lockout duration in cycles (>= 1).
- BLINK_HALF, 12500000: half-period of the lockout red blink in cycles (>= 1).
- FAIL_W, $clog2(MAX_FAIL+1): fail counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- In_valid  in  1  one-cycle strobe; In is valid this cycle.
- In  in  WIDTH  signed difference (attempt - stored).
- LED  out  3  bit0 green, bit1 blue, bit2 red; registered; at most one bit set.
- fail_count  out  FAIL_W  consecutive failures so far; registered.
- locked  out  1  high during lockout.
- busy  out  1  high in SHOW or LOCK, i.e. whenever In_valid is ignored.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high: on any edge with rst=1, state=IDLE, LED=000, fail_count=0, locked=0, busy=0, and all timers are cleared. This applies in any state, including mid-SHOW and mid-LOCK. rst takes priority over In_valid.
- Classification:
  - mag = |In| computed in WIDTH+1 bits, so the most-negative input (-2^(WIDTH-1)) yields 2^(WIDTH-1) without overflow and is always FAR.
  - In==0 is EXACT; 0<mag<=NEAR_THR is NEAR; otherwise FAR.
- State IDLE: LED=000, busy=0, locked=0. On an edge with In_valid=1:
  - EXACT: LED<=001, fail_count<=0, go to SHOW.
  - NEAR: LED<=010, and fail_count+1 is computed.
  - FAR: LED<=100, and fail_count+1 is computed.
  - For NEAR or FAR, if fail_count+1 == MAX_FAIL: go to LOCK, fail_count<=MAX_FAIL. Otherwise fail_count<=fail_count+1 and go to SHOW.
  - Latency: LED changes on the same edge that samples In_valid, i.e. it is visible the cycle after the strobe.
- State SHOW: busy=1. LED holds its value for exactly HOLD_CYCLES cycles, counting from the sampling edge. On the edge ending the last hold cycle, LED<=000 and state returns to IDLE. In_valid is ignored; no queueing.
- State LOCK:
  - Outputs: locked=1, busy=1, green=0, blue=0.
  - Red blink: red is on for the first BLINK_HALF cycles, off for the next BLINK_HALF, and so on. Red is on in the first LOCK cycle.
  - Exit: after exactly LOCK_CYCLES cycles, on one edge, LED<=000, fail_count<=0, locked<=0, and state returns to IDLE.
  - In_valid is ignored throughout LOCK, including EXACT inputs.
- MAX_FAIL=1: the first NEAR/FAR goes directly to LOCK.
- Timers: the hold/lock counter and the blink counter are sized by $clog2 of their maxima. They load on state entry and do not wrap.
- fail_count saturates at MAX_FAIL and never wraps.
- An In_valid held high for several cycles in IDLE is sampled only on the first edge. The next sample can occur only after returning to IDLE.

Test Plan (WIDTH=5, NEAR_THR=3, HOLD_CYCLES=4, MAX_FAIL=3, LOCK_CYCLES=20, BLINK_HALF=2):
1. Reset, then In=0 with a strobe -> LED=001 for exactly 4 cycles, then 000; fail_count=0; busy high for those 4 cycles.
2. Sweep In over -16..15, one strobe per IDLE -> blue only for ±1..±3, green for 0, red otherwise. In=-16 (10000) gives red. LED is never multi-hot.
3. Strobes of In=5, 2, 9 -> LED 100 (fail_count=1), 010 (fail_count=2), then LOCK: locked=1, red pattern 1,1,0,0 repeating for 20 cycles, then LED=000, fail_count=0, locked=0.
4. During SHOW and during LOCK, apply In_valid with In=0 -> no effect: LED, fail_count and timers are unchanged. After returning to IDLE, the next strobe with In=0 gives green.
5. Strobes of In=1 then In=0 -> fail_count goes 1 then 0. Then FAR twice -> fail_count=2, no lock.
6. Assert rst in cycle 2 of SHOW and again in cycle 7 of LOCK -> on the next edge, LED=000, fail_count=0, locked=0, busy=0. In_valid on the same edge as rst is ignored.
